// File: rtl/spi_slave_core.sv
// SPI target core: oversampled SCK/NSS/MOSI, modes 0-3, 8/16/24/32-bit words, 1-entry tx/rx holding registers.
// Define SPI_SLV_ERR_EN to enable the sticky overrun/underrun flags on ovr_o/udr_o.
module spi_slave_core #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cpol_i,
  input  logic        cpha_i,
  input  logic        lsb_i,
  input  logic [1:0]  dsize_i,
  output logic        busy_o,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [31:0] tx_data_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [31:0] rx_data_o,
  output logic        ovr_o,
  output logic        udr_o,
  input  logic        clr_i,
  input  logic        spi_sck_i,
  input  logic        spi_nss_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_en_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

  logic [SYNC_STAGES-1:0] sck_sync, nss_sync, mosi_sync;
  logic sck_q, nss_q;
  logic sck_s, nss_s, mosi_s;

  // NOTE: all clocked state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_sync  <= '0;
      nss_sync  <= '1;
      mosi_sync <= '0;
      sck_q     <= 1'b0;
      nss_q     <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
      nss_sync  <= {nss_sync[SYNC_STAGES-2:0], spi_nss_i};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
      sck_q     <= sck_s;
      nss_q     <= nss_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign nss_s  = nss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  logic sck_rise, sck_fall, nss_fall, nss_rise;
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign nss_fall = ~nss_s & nss_q;
  assign nss_rise = nss_s & ~nss_q;

  logic [1:0] state, state_d;
  logic       cpol_r, cpha_r, lsb_r;
  logic [1:0] dsize_r;
  logic [5:0] bitcnt;
  logic [31:0] tx_sh, rx_sh, tx_hold;
  logic       tx_full;
  logic       rx_valid;
  logic [31:0] rx_data;

  logic       lead_edge, trail_edge, sample_evt, shift_evt, in_xfer, word_done;
  logic [2:0] dsize_p1;
  logic [5:0] word_bits;
  logic [4:0] msb_idx;
  logic [31:0] tx_word, tx_cur, rx_next;
  logic       ovr_evt, udr_evt;

  assign lead_edge  = cpol_r ? sck_fall : sck_rise;
  assign trail_edge = cpol_r ? sck_rise : sck_fall;
  assign in_xfer    = (state == ST_XFER) & ~nss_rise;
  assign sample_evt = in_xfer & (cpha_r ? trail_edge : lead_edge);
  // A shift edge before the word's first sample (leftover trailing edge for cpha=0,
  // first leading edge for cpha=1) only presents bit 0, so it must not advance.
  assign shift_evt  = in_xfer & (cpha_r ? lead_edge : trail_edge) & (bitcnt != 6'd0);

  assign dsize_p1  = {1'b0, dsize_r} + 3'd1;
  assign word_bits = {dsize_p1, 3'b000};
  assign msb_idx   = {dsize_r, 3'b111};
  assign word_done = sample_evt & ((bitcnt + 6'd1) == word_bits);

  assign tx_word = tx_full ? tx_hold : '0;
  assign udr_evt = (state == ST_LOAD) & ~tx_full;
  assign ovr_evt = word_done & rx_valid & ~rx_ready_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rx_next = rx_sh;
    if (lsb_r) rx_next[bitcnt[4:0]] = mosi_s;
    else       rx_next = {rx_sh[30:0], mosi_s};
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (nss_fall) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_XFER;
      ST_XFER: if (word_done) state_d = ST_LOAD;
      default: state_d = ST_IDLE;
    endcase
    if (nss_rise) state_d = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_IDLE;
      cpol_r  <= 1'b0;
      cpha_r  <= 1'b0;
      lsb_r   <= 1'b0;
      dsize_r <= 2'd0;
      bitcnt  <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
    end else begin
      state <= state_d;
      if (state == ST_IDLE && nss_fall) begin
        cpol_r  <= cpol_i;
        cpha_r  <= cpha_i;
        lsb_r   <= lsb_i;
        dsize_r <= dsize_i;
      end
      if (state == ST_LOAD) begin
        tx_sh  <= tx_word;
        bitcnt <= '0;
        rx_sh  <= '0;
      end else begin
        if (shift_evt) tx_sh <= lsb_r ? (tx_sh >> 1) : (tx_sh << 1);
        if (sample_evt) begin
          rx_sh  <= rx_next;
          bitcnt <= bitcnt + 6'd1;
        end
      end
    end
  end

  // Holding registers: a handshake during LOAD refills for the next word, never bypasses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_full  <= 1'b0;
      tx_hold  <= '0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      if (tx_valid_i && !tx_full) begin
        tx_full <= 1'b1;
        tx_hold <= tx_data_i;
      end else if (state == ST_LOAD) begin
        tx_full <= 1'b0;
      end
      if (word_done && (!rx_valid || rx_ready_i)) begin
        rx_valid <= 1'b1;
        rx_data  <= rx_next;
      end else if (rx_valid && rx_ready_i) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_SLV_ERR_EN
  logic ovr_q, udr_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovr_q <= 1'b0;
      udr_q <= 1'b0;
    end else begin
      if (ovr_evt)    ovr_q <= 1'b1;
      else if (clr_i) ovr_q <= 1'b0;
      if (udr_evt)    udr_q <= 1'b1;
      else if (clr_i) udr_q <= 1'b0;
    end
  end
  assign ovr_o = ovr_q;
  assign udr_o = udr_q;
`else
  logic unused_err;
  assign unused_err = clr_i ^ ovr_evt ^ udr_evt;
  assign ovr_o = 1'b0;
  assign udr_o = 1'b0;
`endif

  // During LOAD the outgoing bit comes from the word being loaded so cpha=0 sees it before the first edge.
  assign tx_cur        = (state == ST_LOAD) ? tx_word : tx_sh;
  assign spi_miso_en_o = (state != ST_IDLE);
  assign spi_miso_o    = spi_miso_en_o & (lsb_r ? tx_cur[0] : tx_cur[msb_idx]);
  assign busy_o        = (state != ST_IDLE);
  assign tx_ready_o    = ~tx_full;
  assign rx_valid_o    = rx_valid;
  assign rx_data_o     = rx_data;

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: acts as SPI initiator and peripheral side, hand-computed expectations.
module tb_spi_slave_core;

  localparam int SYNC_STAGES = 2;
  localparam int H = 80;
`ifdef SPI_SLV_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        cpol_i = 1'b0, cpha_i = 1'b0, lsb_i = 1'b0;
  logic [1:0]  dsize_i = 2'd0;
  logic        busy_o, tx_ready_o, rx_valid_o, ovr_o, udr_o;
  logic        tx_valid_i = 1'b0, rx_ready_i = 1'b0, clr_i = 1'b0;
  logic [31:0] tx_data_i = '0, rx_data_o;
  logic        spi_sck = 1'b0, spi_nss = 1'b1, spi_mosi = 1'b0;
  logic        spi_miso_o, spi_miso_en_o;

  int n_checks = 0;
  int n_errors = 0;
  logic        mon_en = 1'b0;
  int          rx_cnt = 0;
  logic [31:0] rx_log [4];
  logic [31:0] din, din2;

  always #5 clk_i = ~clk_i;

  spi_slave_core #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i), .lsb_i(lsb_i), .dsize_i(dsize_i),
    .busy_o(busy_o),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_data_i(tx_data_i),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .rx_data_o(rx_data_o),
    .ovr_o(ovr_o), .udr_o(udr_o), .clr_i(clr_i),
    .spi_sck_i(spi_sck), .spi_nss_i(spi_nss), .spi_mosi_i(spi_mosi),
    .spi_miso_o(spi_miso_o), .spi_miso_en_o(spi_miso_en_o)
  );

  // Records rx words accepted while rx_ready_i is held high.
  always @(negedge clk_i) begin
    if (mon_en && rx_valid_o && rx_ready_i && rx_cnt < 4) begin
      rx_log[rx_cnt] = rx_data_o;
      rx_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_tx(input logic [31:0] d);
    int waited;
    waited = 0;
    @(negedge clk_i);
    while (!tx_ready_o && waited < 100) begin
      @(negedge clk_i);
      waited++;
    end
    check("tx_ready_wait", {31'd0, tx_ready_o}, 32'd1);
    tx_valid_i = 1'b1;
    tx_data_i  = d;
    @(negedge clk_i);
    tx_valid_i = 1'b0;
  endtask

  task automatic drain_rx();
    @(negedge clk_i);
    rx_ready_i = 1'b1;
    @(negedge clk_i);
    rx_ready_i = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk_i);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic frame_start(input logic cpol, input logic cpha, input logic lsb, input logic [1:0] dsz);
    cpol_i  = cpol;
    cpha_i  = cpha;
    lsb_i   = lsb;
    dsize_i = dsz;
    spi_sck = cpol;
    #(H);
    spi_nss = 1'b0;
    #(H);
  endtask

  task automatic frame_end();
    #(H);
    spi_nss = 1'b1;
    #(2 * H);
  endtask

  // Initiator side of one word: w = word size (bit ordering), n = bits actually clocked.
  task automatic spi_word(input logic cpol, input logic cpha, input logic lsb, input int w, input int n,
                          input logic [31:0] dout, output logic [31:0] rd);
    rd = '0;
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = lsb ? i : w - 1 - i;
      if (!cpha) begin
        spi_mosi = dout[idx];
        #(H);
        spi_sck = ~cpol;
        rd[idx] = spi_miso_o;
        #(H);
        spi_sck = cpol;
      end else begin
        spi_sck = ~cpol;
        spi_mosi = dout[idx];
        #(H);
        spi_sck = cpol;
        rd[idx] = spi_miso_o;
        #(H);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_busy",     {31'd0, busy_o},        32'd0);
    check("rst_tx_ready", {31'd0, tx_ready_o},    32'd1);
    check("rst_rx_valid", {31'd0, rx_valid_o},    32'd0);
    check("rst_rx_data",  rx_data_o,              32'd0);
    check("rst_ovr",      {31'd0, ovr_o},         32'd0);
    check("rst_udr",      {31'd0, udr_o},         32'd0);
    check("rst_miso",     {31'd0, spi_miso_o},    32'd0);
    check("rst_miso_en",  {31'd0, spi_miso_en_o}, 32'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // 1: mode 0, 8 bits, MSB first
    push_tx(32'h0000_00A5);
    frame_start(1'b0, 1'b0, 1'b0, 2'b00);
    check("t1_busy",      {31'd0, busy_o},        32'd1);
    check("t1_miso_en",   {31'd0, spi_miso_en_o}, 32'd1);
    check("t1_first_bit", {31'd0, spi_miso_o},    32'd1);
    check("t1_tx_ready",  {31'd0, tx_ready_o},    32'd1);
    spi_word(1'b0, 1'b0, 1'b0, 8, 8, 32'h0000_003C, din);
    check("t1_miso_word", din, 32'h0000_00A5);
    check("t1_rx_valid",  {31'd0, rx_valid_o}, 32'd1);
    check("t1_rx_data",   rx_data_o, 32'h0000_003C);
    frame_end();
    drain_rx();
    check("t1_rx_drained", {31'd0, rx_valid_o}, 32'd0);

    // 2: mode 3, 32 bits, LSB first
    push_tx(32'h1234_5678);
    frame_start(1'b1, 1'b1, 1'b1, 2'b11);
    spi_word(1'b1, 1'b1, 1'b1, 32, 32, 32'hDEAD_BEEF, din);
    frame_end();
    check("t2_miso_word", din, 32'h1234_5678);
    check("t2_rx_data",   rx_data_o, 32'hDEAD_BEEF);
    drain_rx();

    // 3: two back-to-back 16-bit words in one frame
    @(negedge clk_i);
    rx_ready_i = 1'b1;
    mon_en = 1'b1;
    push_tx(32'h0000_1111);
    frame_start(1'b0, 1'b0, 1'b0, 2'b01);
    push_tx(32'h0000_2222);
    spi_word(1'b0, 1'b0, 1'b0, 16, 16, 32'h0000_ABCD, din);
    spi_word(1'b0, 1'b0, 1'b0, 16, 16, 32'h0000_1234, din2);
    frame_end();
    mon_en = 1'b0;
    rx_ready_i = 1'b0;
    check("t3_miso_w0", din,  32'h0000_1111);
    check("t3_miso_w1", din2, 32'h0000_2222);
    check("t3_rx_cnt",  rx_cnt, 32'd2);
    check("t3_rx_w0",   rx_log[0], 32'h0000_ABCD);
    check("t3_rx_w1",   rx_log[1], 32'h0000_1234);

    // 4: empty tx holding at NSS fall -> zeros, underrun
    pulse_clr();
    check("t4_udr_pre", {31'd0, udr_o}, 32'd0);
    frame_start(1'b0, 1'b0, 1'b0, 2'b00);
    spi_word(1'b0, 1'b0, 1'b0, 8, 8, 32'h0000_005A, din);
    frame_end();
    check("t4_miso_zero", din, 32'd0);
    check("t4_udr_set",   {31'd0, udr_o}, {31'd0, ERR_EN});
    check("t4_rx_data",   rx_data_o, 32'h0000_005A);
    drain_rx();
    pulse_clr();
    check("t4_udr_clr",   {31'd0, udr_o}, 32'd0);

    // 5: overrun -- second word dropped while first is unread
    frame_start(1'b0, 1'b0, 1'b0, 2'b00);
    spi_word(1'b0, 1'b0, 1'b0, 8, 8, 32'h0000_0055, din);
    frame_end();
    check("t5_rx_first", rx_data_o, 32'h0000_0055);
    check("t5_ovr_pre",  {31'd0, ovr_o}, 32'd0);
    frame_start(1'b0, 1'b0, 1'b0, 2'b00);
    spi_word(1'b0, 1'b0, 1'b0, 8, 8, 32'h0000_00AA, din);
    frame_end();
    check("t5_rx_kept",  rx_data_o, 32'h0000_0055);
    check("t5_rx_valid", {31'd0, rx_valid_o}, 32'd1);
    check("t5_ovr",      {31'd0, ovr_o}, {31'd0, ERR_EN});
    drain_rx();
    pulse_clr();
    check("t5_ovr_clr",  {31'd0, ovr_o}, 32'd0);

    // 6: NSS rises after 5 of 8 bits, then a full frame
    push_tx(32'h0000_000F);
    frame_start(1'b0, 1'b0, 1'b0, 2'b00);
    spi_word(1'b0, 1'b0, 1'b0, 8, 5, 32'h0000_00FF, din);
    #(H);
    spi_nss = 1'b1;
    repeat (SYNC_STAGES + 2) @(posedge clk_i);
    @(negedge clk_i);
    check("t6_partial_miso", din, 32'h0000_0008);
    check("t6_busy",     {31'd0, busy_o},        32'd0);
    check("t6_miso_en",  {31'd0, spi_miso_en_o}, 32'd0);
    check("t6_rx_valid", {31'd0, rx_valid_o},    32'd0);
    #(2 * H);
    push_tx(32'h0000_0096);
    frame_start(1'b0, 1'b0, 1'b0, 2'b00);
    spi_word(1'b0, 1'b0, 1'b0, 8, 8, 32'h0000_00C3, din);
    frame_end();
    check("t6_miso_full", din, 32'h0000_0096);
    check("t6_rx_data",   rx_data_o, 32'h0000_00C3);
    check("t6_rx_valid2", {31'd0, rx_valid_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
Single-lane SPI target (responder) that receives frames from an external SPI initiator and returns response data on MISO.
- SCK, NSS and MOSI pins are oversampled in the clk_i domain.
- Edges are detected and words of 8/16/24/32 bits are shifted.
- Each direction has a 1-entry holding register with a valid/ready handshake toward the peripheral's register/FIFO layer.
- Mode 0–3 compatible with the team's SPI master core.

Parameters:
SYNC_STAGES, 2, synchronizer depth on spi_sck_i, spi_nss_i, spi_mosi_i (min 2)

Ports:
clk_i  input  1  system clock; must run ≥4× SCK frequency
rst_n_i  input  1  asynchronous active-low reset
cpol_i  input  1  SCK idle level
cpha_i  input  1  0: sample on leading edge; 1: sample on trailing edge
lsb_i  input  1  1: LSB first; 0: MSB first
dsize_i  input  2  word size: 00=8, 01=16, 10=24, 11=32 bits
busy_o  output  1  NSS (synchronized) low and transfer active
tx_valid_i  input  1  tx word offered
tx_ready_o  output  1  tx holding register empty
tx_data_i  input  32  tx word; right-aligned, bits [N-1:0] used
rx_valid_o  output  1  rx holding register full
rx_ready_i  input  1  rx word accepted
rx_data_o  output  32  rx word, right-aligned, upper bits zero
ovr_o  output  1  sticky overrun flag (optional feature)
udr_o  output  1  sticky underrun flag (optional feature)
clr_i  input  1  clears ovr_o/udr_o
spi_sck_i  input  1  SPI clock pin
spi_nss_i  input  1  chip select pin, active low
spi_mosi_i  input  1  data in
spi_miso_o  output  1  data out
spi_miso_en_o  output  1  MISO output enable (0 = high-Z)

Behaviour:
- Reset values: busy_o=0, tx_ready_o=1, rx_valid_o=0, rx_data_o=0, ovr_o=0, udr_o=0, spi_miso_o=0, spi_miso_en_o=0. Reset mid-transfer aborts everything; holding registers are emptied.
- Pin inputs pass through SYNC_STAGES flops. The edge detector compares the last two synchronized SCK samples.
- Edge roles:
  - leading edge = rising if cpol=0, falling if cpol=1
  - sample edge = leading if cpha=0, else trailing
  - shift edge = the other edge
- cpol/cpha/lsb/dsize are captured at NSS fall; changes during NSS low are ignored.
- FSM states: IDLE, LOAD, XFER.
  - IDLE: miso_en=0. On synchronized NSS fall → LOAD.
  - LOAD (1 cycle): tx shift reg ← holding register and holding register emptied; if holding is empty, shift reg ← 0 and underrun is flagged. bitcnt ← 0. miso_en=1. → XFER.
  - XFER:
    - Sample edge: rx shift ← MOSI; bitcnt+1.
    - Shift edge: advance tx shift reg. Exception: with cpha=1 the first leading edge of the word only presents bit 0 and does not advance.
    - When bitcnt reaches N=8*(dsize+1) on a sample edge: rx word → rx holding register, then → LOAD for a back-to-back word.
  - Any state, synchronized NSS rise: → IDLE; partial rx word discarded; a tx word already loaded is consumed; miso_en=0 the next cycle.
- MISO is driven from shift reg bit N-1 (MSB first) or bit 0 (LSB first). With cpha=0 the first bit is valid from LOAD onward, before the first SCK edge.
- rx_valid_o rises exactly 1 cycle after the synchronized completing sample edge, i.e. ≤ SYNC_STAGES+2 clk_i after the pin edge.
- Handshakes:
  - tx transfer when tx_valid_i&tx_ready_o.
  - rx transfer when rx_valid_o&rx_ready_i; rx_valid_o falls next cycle.
- Simultaneous events:
  - tx handshake in the same cycle as LOAD: LOAD uses the old (empty) holding content and the new word fills holding for the next word. No bypass.
  - rx completion with rx_ready_i high in the same cycle: new word stored, rx_valid_o stays 1, no overrun.
  - rx completion with rx_valid_o=1 and rx_ready_i=0: new word dropped, old word kept, overrun flagged.
- busy_o = state≠IDLE.

Optional Feature:
SPI_SLV_ERR_EN
- Defined: ovr_o/udr_o set on overrun/underrun events and hold until clr_i=1. If clr_i and an event occur in the same cycle, set wins.
- Undefined: ovr_o=udr_o=0 constantly and clr_i is ignored. Drop/zero-fill behaviour is unchanged.

Test Plan:
1. Mode 0, dsize=00, MSB first, tx 0xA5 preloaded; master sends 0x3C → rx_data_o=0x3C with rx_valid_o=1; MISO bit sequence 1,0,1,0,0,1,0,1.
2. Mode 3, dsize=11, lsb_i=1, tx 0x12345678; master sends 0xDEADBEEF → rx_data_o=0xDEADBEEF; master captures 0x12345678.
3. Two back-to-back 16-bit words in one NSS low, tx 0x1111 then 0x2222 supplied in time → rx_valid_o pulses twice; MISO returns 0x1111, 0x2222.
4. tx holding empty at NSS fall → MISO all zeros; udr_o=1 (macro on) until clr_i pulse, then 0; udr_o=0 always with macro off.
5. Word 0x55 unread, second word 0xAA arrives with rx_ready_i=0 → rx_data_o stays 0x55; ovr_o=1.
6. NSS rises after 5 of 8 bits → no rx_valid_o; spi_miso_en_o=0; busy_o=0 within SYNC_STAGES+2 cycles. Next full frame is received correctly.
